// File: rtl/simple_risc_pkg.sv
// Shared decode constants for the simpleRISC core: opcode/op/cond fields,
// flag bit positions and the branch-class encoding used by the PC sequencer.
package simple_risc_pkg;

   localparam logic [2:0] OPC_B   = 3'b001;
   localparam logic [2:0] OPC_BL  = 3'b010;
   localparam logic [2:0] OPC_BLX = 3'b010;
   localparam logic [2:0] OPC_BX  = 3'b010;

   localparam logic [1:0] OP_B    = 2'b00;
   localparam logic [1:0] OP_BL   = 2'b11;
   localparam logic [1:0] OP_BLX  = 2'b10;
   localparam logic [1:0] OP_BX   = 2'b00;

   localparam logic [2:0] COND_AL  = 3'b000;
   localparam logic [2:0] COND_EQ  = 3'b001;
   localparam logic [2:0] COND_NE  = 3'b010;
   localparam logic [2:0] COND_LT  = 3'b011;
   localparam logic [2:0] COND_LE  = 3'b100;
   localparam logic [2:0] COND_BLX = 3'b111;

   localparam int Z_BIT = 0;
   localparam int N_BIT = 1;
   localparam int V_BIT = 2;

   typedef enum logic [2:0] {
      BR_NONE     = 3'd0,
      BR_COND     = 3'd1,
      BR_CALL_REL = 3'd2,
      BR_CALL_REG = 3'd3,
      BR_RET      = 3'd4
   } br_kind_e;

   // Evaluate a B-family condition against the {V,N,Z} flag vector.
   function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] flags);
      logic lt;
      lt = flags[N_BIT] ^ flags[V_BIT];
      case (c)
         COND_AL: cond_holds = 1'b1;
         COND_EQ: cond_holds = flags[Z_BIT];
         COND_NE: cond_holds = ~flags[Z_BIT];
         COND_LT: cond_holds = lt;
         COND_LE: cond_holds = lt | flags[Z_BIT];
         default: cond_holds = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push while full overwrites the oldest
// entry and raises a sticky overflow flag; pops are only issued when non-empty.
module pc_ras #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] top,
   output logic              empty,
   output logic              overflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic [PTR_W-1:0]  ptr_next_s;
   logic [PTR_W-1:0]  ptr_prev_s;
   logic              full_s;

   // Pointer neighbours with explicit wrap so non-power-of-2 widths stay safe.
   always_comb begin
      ptr_next_s = (wr_ptr_r == PTR_MAX)  ? PTR_ZERO : (wr_ptr_r + PTR_ONE);
      ptr_prev_s = (wr_ptr_r == PTR_ZERO) ? PTR_MAX  : (wr_ptr_r - PTR_ONE);
   end

   assign top    = mem_r[ptr_prev_s];
   assign empty  = (count_r == CNT_ZERO);
   assign full_s = (count_r == CNT_FULL);

   // Pointer, occupancy and sticky overflow bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         overflow <= 1'b0;
      end else if (push) begin
         wr_ptr_r <= ptr_next_s;
         if (full_s) begin
            overflow <= 1'b1;
         end else begin
            count_r <= count_r + CNT_ONE;
         end
      end else if (pop) begin
         wr_ptr_r <= ptr_prev_s;
         count_r  <= count_r - CNT_ONE;
      end
   end

   // Entry storage; contents are only observed while the stack is non-empty.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: owns the PC, resolves branches/calls/returns on br_en,
// increments on inc_en, and tracks call depth through a return-address stack.
module pc_sequencer
   import simple_risc_pkg::*;
#(
   parameter int PC_W      = 9,
   parameter int IMM_W     = 8,
   parameter int RAS_DEPTH = 4,
   parameter int RESET_PC  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_en,
   input  logic             br_en,
   input  logic [2:0]       opcode,
   input  logic [1:0]       op,
   input  logic [2:0]       cond,
   input  logic [IMM_W-1:0] imm,
   input  logic [2:0]       zonk,
   input  logic [PC_W-1:0]  rd_data,
   output logic [PC_W-1:0]  pc_out,
   output logic             taken,
   output logic             link_we,
   output logic [PC_W-1:0]  link_out,
   output logic             ras_mismatch,
   output logic             ras_overflow,
   output logic             ras_underflow
);

   localparam int EXT_W = PC_W - IMM_W;
   localparam logic [PC_W-1:0] PC_RESET = PC_W'(RESET_PC);
   localparam logic [PC_W-1:0] PC_ONE   = PC_W'(1);
   localparam logic [PC_W-1:0] PC_ZERO  = PC_W'(0);

   br_kind_e          kind_s;
   logic [PC_W-1:0]   rel_target_s;
   logic              cond_ok_s;
   logic              ras_push_s;
   logic              ras_pop_s;
   logic [PC_W-1:0]   ras_top_s;
   logic              ras_empty_s;

   // Classify the instruction; anything outside the branch encodings is inert.
   always_comb begin
      kind_s = BR_NONE;
      if ((opcode == OPC_B) && (op == OP_B)) begin
         case (cond)
            COND_AL, COND_EQ, COND_NE, COND_LT, COND_LE: kind_s = BR_COND;
            default:                                     kind_s = BR_NONE;
         endcase
      end else if ((opcode == OPC_BL) && (op == OP_BL)) begin
         kind_s = BR_CALL_REL;
      end else if ((opcode == OPC_BLX) && (op == OP_BLX) && (cond == COND_BLX)) begin
         kind_s = BR_CALL_REG;
      end else if ((opcode == OPC_BX) && (op == OP_BX)) begin
         kind_s = BR_RET;
      end else begin
         kind_s = BR_NONE;
      end
   end

   assign rel_target_s = pc_out + {{EXT_W{imm[IMM_W-1]}}, imm};
   assign cond_ok_s    = cond_holds(cond, zonk);
   assign ras_push_s   = br_en && ((kind_s == BR_CALL_REL) || (kind_s == BR_CALL_REG));
   assign ras_pop_s    = br_en && (kind_s == BR_RET) && !ras_empty_s;

   pc_ras #(
      .DATA_W (PC_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push_s),
      .pop       (ras_pop_s),
      .push_data (pc_out),
      .top       (ras_top_s),
      .empty     (ras_empty_s),
      .overflow  (ras_overflow)
   );

   // PC register and all registered outputs; br_en takes priority over inc_en.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_out        <= PC_RESET;
         taken         <= 1'b0;
         link_we       <= 1'b0;
         link_out      <= PC_ZERO;
         ras_mismatch  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         taken        <= 1'b0;
         link_we      <= 1'b0;
         ras_mismatch <= 1'b0;
         if (br_en) begin
            case (kind_s)
               BR_COND: begin
                  if (cond_ok_s) begin
                     pc_out <= rel_target_s;
                     taken  <= 1'b1;
                  end
               end
               BR_CALL_REL: begin
                  link_out <= pc_out;
                  link_we  <= 1'b1;
                  pc_out   <= rel_target_s;
                  taken    <= 1'b1;
               end
               BR_CALL_REG: begin
                  link_out <= pc_out;
                  link_we  <= 1'b1;
                  pc_out   <= rd_data;
                  taken    <= 1'b1;
               end
               BR_RET: begin
                  pc_out <= rd_data;
                  taken  <= 1'b1;
                  if (ras_empty_s) begin
                     ras_underflow <= 1'b1;
                  end else begin
                     ras_mismatch <= (ras_top_s != rd_data);
                  end
               end
               default: begin
                  pc_out <= pc_out;
               end
            endcase
         end else if (inc_en) begin
            pc_out <= pc_out + PC_ONE;
         end
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer, checked against a queue-based
// model of the PC/branch/return-stack rules.
module tb_pc_sequencer;

   localparam int PC_MOD = 512;
   localparam int DEPTH  = 4;

   logic       clk;
   logic       reset;
   logic       inc_en;
   logic       br_en;
   logic [2:0] opcode;
   logic [1:0] op;
   logic [2:0] cond;
   logic [7:0] imm;
   logic [2:0] zonk;
   logic [8:0] rd_data;
   logic [8:0] pc_out;
   logic       taken;
   logic       link_we;
   logic [8:0] link_out;
   logic       ras_mismatch;
   logic       ras_overflow;
   logic       ras_underflow;

   int total = 0;
   int bad   = 0;

   int m_pc;
   int m_ras[$];
   int m_lout;
   bit m_taken, m_lwe, m_mis, m_ovf, m_unf;

   pc_sequencer #(
      .PC_W(9), .IMM_W(8), .RAS_DEPTH(DEPTH), .RESET_PC(0)
   ) dut (
      .clk(clk), .reset(reset), .inc_en(inc_en), .br_en(br_en),
      .opcode(opcode), .op(op), .cond(cond), .imm(imm), .zonk(zonk),
      .rd_data(rd_data), .pc_out(pc_out), .taken(taken), .link_we(link_we),
      .link_out(link_out), .ras_mismatch(ras_mismatch),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: state after one clock edge given these inputs.
   task automatic model(input bit rst, input bit inc, input bit br, input logic [7:0] code,
                        input logic [7:0] imm_v, input logic [2:0] fl, input logic [8:0] rd);
      int off, tgt;
      bit z, n, v, ok;
      m_taken = 0; m_lwe = 0; m_mis = 0;
      if (rst) begin
         m_pc = 0; m_ras.delete(); m_ovf = 0; m_unf = 0; m_lout = 0;
         return;
      end
      if (br) begin
         off = (imm_v >= 8'd128) ? int'(imm_v) - 256 : int'(imm_v);
         tgt = ((m_pc + off) % PC_MOD + PC_MOD) % PC_MOD;
         z = fl[0]; n = fl[1]; v = fl[2];
         if (code >= 8'h20 && code <= 8'h24) begin
            case (code - 8'h20)
               0: ok = 1;
               1: ok = z;
               2: ok = !z;
               3: ok = (n != v);
               default: ok = (n != v) || z;
            endcase
            if (ok) begin m_pc = tgt; m_taken = 1; end
         end else if (code[7:3] == 5'b01011 || code == 8'h57) begin
            m_lout = m_pc; m_lwe = 1; m_taken = 1;
            m_ras.push_back(m_pc);
            if (m_ras.size() > DEPTH) begin
               void'(m_ras.pop_front());
               m_ovf = 1;
            end
            m_pc = (code == 8'h57) ? int'(rd) : tgt;
         end else if (code[7:3] == 5'b01000) begin
            m_taken = 1;
            if (m_ras.size() == 0) m_unf = 1;
            else m_mis = (m_ras.pop_back() != int'(rd));
            m_pc = int'(rd);
         end
      end else if (inc) begin
         m_pc = (m_pc + 1) % PC_MOD;
      end
   endtask

   task automatic check_all();
      check("pc_out", 32'(pc_out), 32'(m_pc));
      check("taken", 32'(taken), 32'(m_taken));
      check("link_we", 32'(link_we), 32'(m_lwe));
      check("link_out", 32'(link_out), 32'(m_lout));
      check("ras_mismatch", 32'(ras_mismatch), 32'(m_mis));
      check("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
      check("ras_underflow", 32'(ras_underflow), 32'(m_unf));
   endtask

   task automatic step(input bit rst, input bit inc, input bit br, input logic [7:0] code,
                       input logic [7:0] imm_v, input logic [2:0] fl, input logic [8:0] rd);
      @(negedge clk);
      reset = rst; inc_en = inc; br_en = br;
      opcode = code[7:5]; op = code[4:3]; cond = code[2:0];
      imm = imm_v; zonk = fl; rd_data = rd;
      model(rst, inc, br, code, imm_v, fl, rd);
      @(posedge clk);
      #1;
      check_all();
   endtask

   // Walk the PC to a target using unconditional relative branches.
   task automatic goto(input int target);
      int d;
      logic [31:0] dv;
      while (m_pc != target) begin
         d = ((target - m_pc) % PC_MOD + PC_MOD) % PC_MOD;
         if (d >= 256) d = d - PC_MOD;
         if (d > 127) d = 127;
         if (d < -128) d = -128;
         dv = 32'(d);
         step(0, 0, 1, 8'h20, dv[7:0], 3'b000, 9'd0);
      end
   endtask

   initial begin
      int r;
      logic [8:0] rd_v;
      reset = 1'b0; inc_en = 1'b0; br_en = 1'b0; opcode = 3'd0; op = 2'd0;
      cond = 3'd0; imm = 8'd0; zonk = 3'd0; rd_data = 9'd0;

      // 1: reset then sequential fetch
      step(1, 0, 0, 8'h00, 8'h00, 3'b000, 9'd0);
      check("t1_reset_pc", 32'(pc_out), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         step(0, 1, 0, 8'h00, 8'h00, 3'b000, 9'd0);
         check("t1_inc_pc", 32'(pc_out), 32'(i));
      end

      // 2: BEQ backwards, taken and not taken
      goto(5);
      step(0, 0, 1, 8'h21, 8'hFE, 3'b001, 9'd0);
      check("t2_beq_taken_pc", 32'(pc_out), 32'd3);
      check("t2_beq_taken", 32'(taken), 32'd1);
      goto(5);
      step(0, 0, 1, 8'h21, 8'hFE, 3'b000, 9'd0);
      check("t2_beq_nt_pc", 32'(pc_out), 32'd5);

      // 3: wrap on increment and on branch target
      goto(9'h1FF);
      step(0, 1, 0, 8'h00, 8'h00, 3'b000, 9'd0);
      check("t3_inc_wrap", 32'(pc_out), 32'd0);
      goto(9'h1F0);
      step(0, 0, 1, 8'h20, 8'h20, 3'b000, 9'd0);
      check("t3_br_wrap", 32'(pc_out), 32'h010);

      // 4: BLT / BLE
      goto(10);
      step(0, 0, 1, 8'h23, 8'h04, 3'b010, 9'd0);
      check("t4_blt_pc", 32'(pc_out), 32'd14);
      step(0, 0, 1, 8'h24, 8'h04, 3'b001, 9'd0);
      check("t4_ble_z", 32'(taken), 32'd1);
      step(0, 0, 1, 8'h24, 8'h04, 3'b000, 9'd0);
      check("t4_ble_none", 32'(taken), 32'd0);

      // 5: call, matched return, return on empty stack
      step(1, 0, 0, 8'h00, 8'h00, 3'b000, 9'd0);
      goto(20);
      step(0, 0, 1, 8'h58, 8'h05, 3'b000, 9'd0);
      check("t5_bl_pc", 32'(pc_out), 32'd25);
      check("t5_bl_link", 32'(link_out), 32'd20);
      step(0, 0, 1, 8'h40, 8'h00, 3'b000, 9'd20);
      check("t5_bx_pc", 32'(pc_out), 32'd20);
      check("t5_bx_mis", 32'(ras_mismatch), 32'd0);
      step(0, 0, 1, 8'h40, 8'h00, 3'b000, 9'd7);
      check("t5_bx_empty_pc", 32'(pc_out), 32'd7);
      check("t5_underflow", 32'(ras_underflow), 32'd1);

      // 6: overflow, strobe priority, reset override
      step(1, 0, 0, 8'h00, 8'h00, 3'b000, 9'd0);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h58, 8'h01, 3'b000, 9'd0);
      check("t6_overflow", 32'(ras_overflow), 32'd1);
      step(0, 1, 1, 8'h20, 8'h03, 3'b000, 9'd0);
      check("t6_br_wins", 32'(pc_out), 32'd8);
      step(1, 1, 1, 8'h58, 8'h05, 3'b000, 9'd0);
      check("t6_reset_pc", 32'(pc_out), 32'd0);
      check("t6_reset_ovf", 32'(ras_overflow), 32'd0);

      // Randomized mix of all operations
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 9);
         rd_v = 9'($urandom_range(0, 511));
         if ($urandom_range(0, 39) == 0) begin
            step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom), rd_v);
         end else begin
            case (r)
               0, 1: step(0, 1, 0, 8'($urandom), 8'($urandom), 3'($urandom), rd_v);
               2: step(0, 0, 0, 8'($urandom), 8'($urandom), 3'($urandom), rd_v);
               3, 4: step(0, 0, 1, 8'(8'h20 + 8'($urandom_range(0, 4))), 8'($urandom), 3'($urandom), rd_v);
               5: step(0, 0, 1, 8'(8'h58 + 8'($urandom_range(0, 7))), 8'($urandom), 3'($urandom), rd_v);
               6: step(0, 0, 1, 8'h57, 8'($urandom), 3'($urandom), rd_v);
               7: begin
                  if (m_ras.size() > 0 && $urandom_range(0, 1) == 1) rd_v = 9'(m_ras[$]);
                  step(0, 0, 1, 8'(8'h40 + 8'($urandom_range(0, 7))), 8'($urandom), 3'($urandom), rd_v);
               end
               8: step(0, 1'($urandom_range(0, 1)), 1, 8'($urandom), 8'($urandom), 3'($urandom), rd_v);
               default: step(0, 1, 1, 8'(8'h20 + 8'($urandom_range(0, 4))), 8'($urandom), 3'($urandom), rd_v);
            endcase
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
